// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register target.
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam int ABORT_CNT_W = 8;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin followed by an edge-detect flop.
// INVERT flips the synchronised level before edges are classified.
module spi_sync_edge #(
  parameter logic INIT   = 1'b0,
  parameter logic INVERT = 1'b0
)(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;
  logic l2, l3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= INIT;
      s2 <= INIT;
      s3 <= INIT;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign l2    = s2 ^ INVERT;
  assign l3    = s3 ^ INVERT;
  assign level = l2;
  assign rise  = l2 & ~l3;
  assign fall  = ~l2 & l3;

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI target (any CPOL/CPHA) fronting a small register file.
// Optional abort counter at the top address when SPI_ABORT_CNT_EN is defined.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CMD_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int SR_W      = (DATA_W - 1 > ADDR_W) ? DATA_W - 1 : ADDR_W;

  logic sclk_lvl, lead, trail;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sample, shift;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [SR_W-1:0]        rx_sr;
  logic [DATA_W-1:0]      tx_sr;
  logic [DATA_W-1:0]      regs [NUM_REGS];
  logic [ADDR_W-1:0]      addr_q;
  logic                   rw_q;
  logic                   miso_q;
  logic                   armed;
  logic [ADDR_W:0]        cmd_word;
  logic [DATA_W-1:0]      wdata;
  logic                   last_cmd, last_bit;
  logic                   unused_edges;

  // The cs_n synchroniser resets as if selected, so a select held across reset
  // never looks like a fresh fall; only a seen rise arms the next frame.
  spi_sync_edge #(.INIT(CPOL != 0), .INVERT(CPOL != 0)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk), .level(sclk_lvl), .rise(lead), .fall(trail)
  );
  spi_sync_edge #(.INIT(1'b0), .INVERT(1'b0)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.INIT(1'b0), .INVERT(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

  assign sample   = (CPHA != 0) ? trail : lead;
  assign shift    = (CPHA != 0) ? lead  : trail;
  assign cmd_word = {rx_sr[ADDR_W-1:0], mosi_lvl};
  assign wdata    = {rx_sr[DATA_W-2:0], mosi_lvl};
  assign last_cmd = (cnt_q == CNT_W'(CMD_LEN - 1));
  assign last_bit = (cnt_q == CNT_W'(FRAME_LEN - 1));

`ifdef SPI_ABORT_CNT_EN
  localparam logic [ADDR_W-1:0] ABORT_ADDR = {ADDR_W{1'b1}};
  logic [ABORT_CNT_W-1:0] abort_cnt;

  function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) r = regs[i];
`ifdef SPI_ABORT_CNT_EN
    if (a == ABORT_ADDR) r = DATA_W'(abort_cnt);
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && armed)       state_d = CMD;
      CMD:     if (sample && last_cmd)     state_d = DATA;
      DATA:    if (sample && last_bit)     state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      miso_q    <= 1'b0;
      armed     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef SPI_ABORT_CNT_EN
      abort_cnt <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      if (cs_lvl) armed <= 1'b1;

      if (state_q == IDLE && state_d == CMD) begin
        cnt_q <= '0;
        rx_sr <= '0;
        tx_sr <= '0;
      end

      if ((state_q == CMD || state_q == DATA) && sample) begin
        rx_sr <= {rx_sr[SR_W-2:0], mosi_lvl};
        cnt_q <= cnt_q + 1'b1;
      end

      // Read data is fetched as soon as the address is complete.
      if (state_q == CMD && sample && last_cmd) begin
        rw_q   <= cmd_word[ADDR_W];
        addr_q <= cmd_word[ADDR_W-1:0];
        tx_sr  <= rd_data(cmd_word[ADDR_W-1:0]);
      end

      if (state_q == DATA && sample && last_bit && rw_q) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) begin
            regs[i]   <= wdata;
            wr_strobe <= 1'b1;
            wr_addr   <= addr_q;
          end
        end
`ifdef SPI_ABORT_CNT_EN
        if (addr_q == ABORT_ADDR) begin
          abort_cnt <= '0;
          wr_strobe <= 1'b1;
          wr_addr   <= addr_q;
        end
`endif
      end

`ifdef SPI_ABORT_CNT_EN
      if (cs_rise && (state_q == CMD || state_q == DATA))
        abort_cnt <= sat_inc(abort_cnt);
`endif

      if (state_d != DATA) begin
        miso_q <= 1'b0;
      end else if (state_q == DATA && shift) begin
        miso_q <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_W +: DATA_W] = regs[i];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = armed & ~cs_lvl;

endmodule
